// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment path: funct3 encodings,
// FSM states and per-size base byte enables.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] BE_SB = 4'b0001;
    localparam logic [3:0] BE_SH = 4'b0011;
    localparam logic [3:0] BE_SW = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

endpackage : store_pkg

// File: rtl/store_align_unit_if.sv
// Request and data-memory signals of the store alignment unit.
// slave is the unit's view; master is the pipeline/memory side.
interface store_align_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              busy;
    logic              done;
    logic              fault;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_funct3, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, busy, done, fault
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_funct3, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, busy, done, fault
    );
endinterface : store_align_unit_if

// File: rtl/store_align_unit_lane_align.sv
// Combinational lane shifter: byte enables and data for beat 0 or beat 1
// of a store at byte offset k, plus split/illegal classification.
module store_lane_align
    import store_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  k_i,
    input  logic        beat_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o,
    output logic        split_o,
    output logic        illegal_o
);

    logic [3:0]  base_be;
    logic [31:0] data_sized;
    logic [7:0]  be_wide;
    logic [63:0] data_wide;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        base_be    = 4'b0000;
        data_sized = 32'h0;
        split_o    = 1'b0;
        illegal_o  = 1'b0;
        case (funct3_i)
            F3_SB: begin
                base_be    = BE_SB;
                data_sized = {24'h0, wdata_i[7:0]};
            end
            F3_SH: begin
                base_be    = BE_SH;
                data_sized = {16'h0, wdata_i[15:0]};
                split_o    = (k_i == 2'd3);
            end
            F3_SW: begin
                base_be    = BE_SW;
                data_sized = wdata_i;
                split_o    = (k_i != 2'd0);
            end
            default: illegal_o = 1'b1;
        endcase
    end

    // Shifting into a double-width field yields both beats at once: the low half
    // is beat 0, the high half is what spills into the next word (beat 1).
    assign be_wide   = {4'b0000, base_be} << k_i;
    assign data_wide = {32'h0, data_sized} << {k_i, 3'b000};

    assign be_o   = beat_i ? be_wide[7:4]     : be_wide[3:0];
    assign data_o = beat_i ? data_wide[63:32] : data_wide[31:0];

endmodule : store_lane_align

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts SB/SH/SW from MEM, issues one or two
// word-aligned beats to data memory over valid/ready, reports done/fault.
module store_align_unit
    import store_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    store_align_unit_if.slave  bus
);

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              split_q, split_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic        idle;
    logic [2:0]  al_funct3;
    logic [1:0]  al_k;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_data;
    logic        al_split;
    logic        al_illegal;

    assign idle = (state_q == IDLE);

    // In IDLE the aligner classifies the incoming request for beat 0; afterwards
    // it works on the captured request to produce beat 1.
    assign al_funct3 = idle ? bus.req_funct3   : funct3_q;
    assign al_k      = idle ? bus.req_addr[1:0] : k_q;
    assign al_wdata  = idle ? bus.req_wdata    : wdata_q;

    store_lane_align u_lane_align (
        .funct3_i  (al_funct3),
        .k_i       (al_k),
        .beat_i    (!idle),
        .wdata_i   (al_wdata),
        .be_o      (al_be),
        .data_o    (al_data),
        .split_o   (al_split),
        .illegal_o (al_illegal)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        k_d         = k_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (al_illegal || (al_split && !SPLIT_MISALIGNED)) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        funct3_d    = bus.req_funct3;
                        k_d         = bus.req_addr[1:0];
                        wdata_d     = bus.req_wdata;
                        split_d     = al_split;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = al_data;
                        mem_be_d    = al_be;
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (split_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_wdata_d = al_data;
                        mem_be_d    = al_be;
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b000;
            k_q         <= 2'b00;
            wdata_q     <= 32'h0;
            split_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            k_q         <= k_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.req_ready = idle;
    assign bus.busy      = !idle;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;

endmodule : store_align_unit

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: one split-enabled and one
// split-disabled instance driven from a single linear sequence.
module tb_store_align_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    store_align_unit_if #(.ADDR_W(32)) bus1 ();
    store_align_unit_if #(.ADDR_W(32)) bus0 ();

    store_align_unit #(.SPLIT_MISALIGNED(1'b1), .ADDR_W(32)) dut_split (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    store_align_unit #(.SPLIT_MISALIGNED(1'b0), .ADDR_W(32)) dut_nosplit (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req1(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        bus1.req_valid  = 1'b1;
        bus1.req_addr   = addr;
        bus1.req_wdata  = wdata;
        bus1.req_funct3 = f3;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
        check({tag, ".valid"}, 64'(bus1.mem_valid), 64'(1'b1));
        check({tag, ".addr"},  64'(bus1.mem_addr),  64'(addr));
        check({tag, ".be"},    64'(bus1.mem_be),    64'(be));
        check({tag, ".wdata"}, 64'(bus1.mem_wdata), 64'(wdata));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus1.req_funct3 = 3'b000; bus1.mem_ready = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.req_funct3 = 3'b000; bus0.mem_ready = 1'b1;

        tick();
        tick();
        check("rst.mem_valid", 64'(bus1.mem_valid), 64'(0));
        check("rst.done",      64'(bus1.done),      64'(0));
        check("rst.fault",     64'(bus1.fault),     64'(0));
        check("rst.busy",      64'(bus1.busy),      64'(0));
        check("rst.req_ready", 64'(bus1.req_ready), 64'(1));
        check("rst.mem_addr",  64'(bus1.mem_addr),  64'(0));
        check("rst.mem_wdata", 64'(bus1.mem_wdata), 64'(0));
        check("rst.mem_be",    64'(bus1.mem_be),    64'(0));
        rst = 1'b0;
        tick();

        // SB at offset 2
        req1(32'h0000_1002, 32'hDEAD_BEEF, 3'b000);
        tick();
        bus1.req_valid = 1'b0;
        check_beat("sb", 32'h0000_1000, 4'b0100, 32'h00EF_0000);
        check("sb.busy",      64'(bus1.busy),      64'(1));
        check("sb.req_ready", 64'(bus1.req_ready), 64'(0));
        check("sb.done_early", 64'(bus1.done),     64'(0));
        tick();
        check("sb.done",      64'(bus1.done),      64'(1));
        check("sb.valid_off", 64'(bus1.mem_valid), 64'(0));
        check("sb.ready_back", 64'(bus1.req_ready), 64'(1));
        tick();
        check("sb.done_pulse", 64'(bus1.done),     64'(0));

        // SH at offset 1
        req1(32'h0000_2001, 32'h0000_CAFE, 3'b001);
        tick();
        bus1.req_valid = 1'b0;
        check_beat("sh", 32'h0000_2000, 4'b0110, 32'h00CA_FE00);
        tick();
        check("sh.done", 64'(bus1.done), 64'(1));
        tick();

        // SW at offset 3: split into two beats
        req1(32'h0000_3003, 32'h1122_3344, 3'b010);
        tick();
        bus1.req_valid = 1'b0;
        check_beat("sw3.b0", 32'h0000_3000, 4'b1000, 32'h4400_0000);
        tick();
        check_beat("sw3.b1", 32'h0000_3004, 4'b0111, 32'h0011_2233);
        check("sw3.no_done_b1", 64'(bus1.done), 64'(0));
        tick();
        check("sw3.done",  64'(bus1.done),      64'(1));
        check("sw3.valid", 64'(bus1.mem_valid), 64'(0));
        tick();
        check("sw3.single_done", 64'(bus1.done), 64'(0));

        // SH straddling the top of the address space
        req1(32'hFFFF_FFFF, 32'h0000_ABCD, 3'b001);
        tick();
        bus1.req_valid = 1'b0;
        check_beat("shwrap.b0", 32'hFFFF_FFFC, 4'b1000, 32'hCD00_0000);
        tick();
        check_beat("shwrap.b1", 32'h0000_0000, 4'b0001, 32'h0000_00AB);
        tick();
        check("shwrap.done", 64'(bus1.done), 64'(1));
        tick();

        // SW with memory stalling for 5 cycles, then back-to-back SB
        bus1.mem_ready = 1'b0;
        req1(32'h0000_4000, 32'hA5A5_5A5A, 3'b010);
        tick();
        bus1.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_beat("stall", 32'h0000_4000, 4'b1111, 32'hA5A5_5A5A);
            check("stall.no_done", 64'(bus1.done), 64'(0));
            tick();
        end
        check_beat("stall.end", 32'h0000_4000, 4'b1111, 32'hA5A5_5A5A);
        bus1.mem_ready = 1'b1;
        tick();
        check("stall.done",      64'(bus1.done),      64'(1));
        check("stall.req_ready", 64'(bus1.req_ready), 64'(1));
        req1(32'h0000_4005, 32'h0000_0077, 3'b000);
        tick();
        bus1.req_valid = 1'b0;
        check_beat("b2b", 32'h0000_4004, 4'b0010, 32'h0000_7700);
        check("b2b.done_clear", 64'(bus1.done), 64'(0));
        tick();
        check("b2b.done", 64'(bus1.done), 64'(1));
        tick();

        // Illegal funct3 values
        req1(32'h0000_6000, 32'h1234_5678, 3'b011);
        tick();
        bus1.req_valid = 1'b0;
        check("ill011.fault", 64'(bus1.fault),     64'(1));
        check("ill011.valid", 64'(bus1.mem_valid), 64'(0));
        check("ill011.busy",  64'(bus1.busy),      64'(0));
        tick();
        check("ill011.fault_pulse", 64'(bus1.fault),     64'(0));
        check("ill011.valid2",      64'(bus1.mem_valid), 64'(0));
        req1(32'h0000_6000, 32'h1234_5678, 3'b100);
        tick();
        bus1.req_valid = 1'b0;
        check("ill100.fault", 64'(bus1.fault),     64'(1));
        check("ill100.valid", 64'(bus1.mem_valid), 64'(0));
        tick();

        // Misaligned SW with splitting disabled
        bus0.req_valid  = 1'b1;
        bus0.req_addr   = 32'h0000_5002;
        bus0.req_wdata  = 32'hCAFE_F00D;
        bus0.req_funct3 = 3'b010;
        tick();
        bus0.req_valid = 1'b0;
        check("nosplit.fault", 64'(bus0.fault),     64'(1));
        check("nosplit.valid", 64'(bus0.mem_valid), 64'(0));
        check("nosplit.busy",  64'(bus0.busy),      64'(0));
        tick();
        check("nosplit.fault_pulse", 64'(bus0.fault),     64'(0));
        check("nosplit.valid2",      64'(bus0.mem_valid), 64'(0));

        // Reset during BEAT0 of a split SW
        bus1.mem_ready = 1'b0;
        req1(32'h0000_7001, 32'h0BAD_F00D, 3'b010);
        tick();
        bus1.req_valid = 1'b0;
        check("rstmid.valid_before", 64'(bus1.mem_valid), 64'(1));
        rst = 1'b1;
        tick();
        check("rstmid.valid", 64'(bus1.mem_valid), 64'(0));
        check("rstmid.busy",  64'(bus1.busy),      64'(0));
        check("rstmid.done",  64'(bus1.done),      64'(0));
        check("rstmid.fault", 64'(bus1.fault),     64'(0));
        rst = 1'b0;
        bus1.mem_ready = 1'b1;
        tick();
        check("rstmid.done_after",  64'(bus1.done),      64'(0));
        check("rstmid.ready_after", 64'(bus1.req_ready), 64'(1));
        check("rstmid.valid_after", 64'(bus1.mem_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_store_align_unit

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
Write-side counterpart of the writeback load extractor. Accepts SB/SH/SW requests from the MEM stage and generates word-aligned address, lane-shifted write data and byte enables for data memory. Drives the memory through a valid/ready handshake. When SPLIT_MISALIGNED=1, a misaligned SH/SW is split into two word beats. Sits between the EX/MEM pipeline register and the data-memory port; its busy output stalls the pipeline.

Parameters:
SPLIT_MISALIGNED, 1, 1 = misaligned stores split into two beats; 0 = misaligned stores fault with no memory access
ADDR_W, 32, byte address width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_addr  input  ADDR_W  byte address of store
req_wdata  input  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
req_funct3  input  3  000 SB, 001 SH, 010 SW
mem_valid  output  1  memory beat valid
mem_ready  input  1  memory accepts beat
mem_addr  output  ADDR_W  word-aligned address, bits [1:0] = 00
mem_wdata  output  32  lane-aligned data; disabled lanes driven 0
mem_be  output  4  byte enables, bit i = byte lane i
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final beat handshake
fault  output  1  one-cycle pulse for illegal funct3, or for a misaligned store when SPLIT_MISALIGNED=0

Behaviour:
- Reset: state IDLE. mem_valid, done, fault and busy are 0. mem_addr, mem_wdata and mem_be are 0. req_ready is 1.
- Accept condition: req_valid && req_ready. At acceptance, register addr, wdata, funct3 and offset k = addr[1:0].
- Misalignment rule: SH with k=3 is misaligned. SW with k≠0 is misaligned. SB is never misaligned.
- Fault path: illegal funct3 (011, 1xx), or misaligned with SPLIT_MISALIGNED=0, produces a fault pulse the cycle after acceptance. State stays IDLE. No mem_valid is issued.
- States: IDLE -> BEAT0 on legal accept. BEAT0 -> BEAT1 on mem_ready if split; otherwise BEAT0 -> IDLE on mem_ready. BEAT1 -> IDLE on mem_ready.
- done: pulses in the cycle after the final handshake. req_ready is already 1 in that cycle, so back-to-back requests are allowed.
- Outputs are registered. mem_valid rises in the cycle after acceptance. Minimum latency from accept to done is 2 cycles for a single beat and 3 cycles for a split.
- mem_valid stays high and mem_addr/mem_wdata/mem_be stay stable until mem_ready. Holding a beat indefinitely is legal.
- Beat 0: mem_addr = {addr[31:2],2'b00}. mem_be = (base_be << k)[3:0]. mem_wdata = (data << 8k)[31:0].
  - base_be: SB = 0001, SH = 0011, SW = 1111.
  - data is wdata masked to the access size.
- Beat 1 (split only): mem_addr = beat-0 address + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000). mem_be = base_be >> (4-k). mem_wdata = data >> (32-8k).
- Beat 1 is issued in the cycle after the beat-0 handshake. mem_valid stays high with no bubble.
- Reset mid-operation: in the next cycle mem_valid drops and state returns to IDLE. No done and no fault are issued. Any beat already accepted by memory is not undone.
- req_valid asserted while busy is ignored. The requester must hold the request until req_ready.

Decomposition:
- Shared package store_pkg:
  - funct3 constants F3_SB, F3_SH, F3_SW
  - state enum {IDLE, BEAT0, BEAT1}
  - base byte-enable constants
- One combinational sub-module, store_lane_align. Inputs: funct3, k, beat select, wdata. Outputs: be, aligned data, split flag, illegal flag. This keeps the FSM free of shift logic and is reusable by a future store buffer.

Test Plan:
- SB addr=0x1002, wdata=0xDEADBEEF, mem_ready tied 1 -> one beat: mem_addr=0x1000, be=0100, wdata=0x00EF0000; done 2 cycles after accept.
- SH addr=0x2001, wdata=0x0000CAFE -> one beat: mem_addr=0x2000, be=0110, wdata=0x00CAFE00.
- SW addr=0x3003, wdata=0x11223344, SPLIT=1 -> beat0: mem_addr=0x3000, be=1000, wdata=0x44000000; beat1: mem_addr=0x3004, be=0111, wdata=0x00112233; single done.
- SH addr=0xFFFFFFFF, wdata=0xABCD -> beat0: mem_addr=0xFFFFFFFC, be=1000, wdata=0xCD000000; beat1: mem_addr=0x00000000, be=0001, wdata=0x000000AB.
- SW addr=0x4000 with mem_ready low for 5 cycles -> mem_valid and outputs held stable; done one cycle after mem_ready; a back-to-back SB is accepted in the done cycle.
- funct3=011, then SW addr=0x5002 with SPLIT=0, then rst during BEAT0 of a split SW -> fault pulses with no mem_valid for the first two; for the reset case mem_valid=0 next cycle, state IDLE, no done.
